// File: rtl/ds_token_collector.sv
// Gathers CIN channel-major HOUT x HOUT slices, then streams one CIN-byte token
// per handshake in raster order (row, then column).
//
// state   | meaning
// COLLECT | accepting slices, ch_cnt is the plane written next
// STREAM  | presenting token (row, col), advancing on each handshake
module ds_token_collector #(
  parameter int CIN  = 64,
  parameter int HOUT = 19
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] slice_in [0:HOUT-1][0:HOUT-1],
  input  logic       slice_valid,
  output logic       in_ready,
  output logic [7:0] out_data [0:CIN-1],
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       done,
  output logic       err_drop
);

  localparam int CW = (CIN > 1) ? $clog2(CIN) : 1;
  localparam int PW = (HOUT > 1) ? $clog2(HOUT) : 1;

  typedef enum logic {COLLECT, STREAM} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   ch_cnt, ch_cnt_nxt;
  logic [PW-1:0]   row, row_nxt;
  logic [PW-1:0]   col, col_nxt;
  logic            done_nxt;
  logic            capture;
  logic            at_last;

  // No reset on the buffer: every plane is rewritten before it is read.
  logic [7:0] buffer [0:CIN-1][0:HOUT-1][0:HOUT-1];

  assign at_last = (row == PW'(HOUT - 1)) && (col == PW'(HOUT - 1));

  always_comb begin
    state_nxt  = state;
    ch_cnt_nxt = ch_cnt;
    row_nxt    = row;
    col_nxt    = col;
    done_nxt   = 1'b0;
    capture    = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    case (state)
      COLLECT: begin
        in_ready = 1'b1;
        if (slice_valid) begin
          capture = 1'b1;
          if (ch_cnt == CW'(CIN - 1)) begin
            ch_cnt_nxt = '0;
            state_nxt  = STREAM;
          end else begin
            ch_cnt_nxt = ch_cnt + CW'(1);
          end
        end
      end
      STREAM: begin
        out_valid = 1'b1;
        out_last  = at_last;
        if (out_ready) begin
          if (col == PW'(HOUT - 1)) begin
            col_nxt = '0;
            if (row == PW'(HOUT - 1)) begin
              row_nxt   = '0;
              state_nxt = COLLECT;
              done_nxt  = 1'b1;
            end else begin
              row_nxt = row + PW'(1);
            end
          end else begin
            col_nxt = col + PW'(1);
          end
        end
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= COLLECT;
      ch_cnt   <= '0;
      row      <= '0;
      col      <= '0;
      done     <= 1'b0;
      err_drop <= 1'b0;
    end else begin
      state    <= state_nxt;
      ch_cnt   <= ch_cnt_nxt;
      row      <= row_nxt;
      col      <= col_nxt;
      done     <= done_nxt;
      err_drop <= err_drop | (slice_valid & ~in_ready);
    end
  end

  always_ff @(posedge clk) begin
    if (capture) buffer[ch_cnt] <= slice_in;
  end

  always_comb begin
    for (int c = 0; c < CIN; c++) out_data[c] = buffer[c][row][col];
  end

endmodule
